// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - CPU data-bus bundle shared by the UART transmitter and its bus master
interface mmio_uart_tx_if;
  logic [31:0] AddressBus;
  logic [31:0] WrData;
  logic [2:0]  ControlBus;
  logic [31:0] RdData;

  modport master (
    output AddressBus,
    output WrData,
    output ControlBus,
    input  RdData
  );

  modport slave (
    input  AddressBus,
    input  WrData,
    input  ControlBus,
    output RdData
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO and baud divisor
module mmio_uart_tx #(
  parameter logic [31:0]      BASE_ADDR   = 32'h0000_1000,
  parameter int               FIFO_DEPTH  = 4,
  parameter int               DIV_W       = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16
) (
  input  logic               InputClk,
  input  logic               rst,
  mmio_uart_tx_if.slave      bus,
  output logic               tx,
  output logic               busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [7:0]         fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   div_act_q, div_act_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_q;

  logic       sel, rd_en, wr_en;
  logic [1:0] offset;
  logic       full, empty, pop, push_req, push, ovf_set, ovf_clr, bit_end;
  logic [DIV_W-1:0] wr_div;
  logic       unused_bits;

  assign sel         = (bus.AddressBus[31:4] == BASE_ADDR[31:4]);
  assign offset      = bus.AddressBus[3:2];
  assign rd_en       = sel && bus.ControlBus[1];
  assign wr_en       = sel && bus.ControlBus[2];
  assign unused_bits = ^{bus.AddressBus[1:0], bus.ControlBus[0], bus.WrData};

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push_req = wr_en && (offset == 2'd0);
  // A full FIFO still takes a push when the transmitter frees a slot on the same edge.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = wr_en && (offset == 2'd1) && bus.WrData[3];
  assign bit_end  = (div_cnt_q == div_act_q - DIV_W'(1));
  assign wr_div   = bus.WrData[DIV_W-1:0];

  always_comb begin
    state_d   = state_q;
    div_act_d = div_act_q;
    div_cnt_d = div_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = fifo_q[rd_ptr_q];
          div_act_d = div_q;
          div_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          div_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          div_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          div_cnt_d = '0;
          if (!empty) begin
            pop       = 1'b1;
            shift_d   = fifo_q[rd_ptr_q];
            div_act_d = div_q;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // tx follows the next state so the line changes on the same edge as the FSM.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    ovf_d   = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    div_d   = div_q;
    if (wr_en && (offset == 2'd2)) begin
      div_d = (wr_div == '0) ? DIV_W'(1) : wr_div;
    end
  end

  always_ff @(posedge InputClk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= bus.WrData[7:0];
    end
  end

  always_ff @(posedge InputClk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      div_q     <= DEFAULT_DIV;
      div_act_q <= DEFAULT_DIV;
      div_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      div_act_q <= div_act_d;
      div_cnt_q <= div_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  always_comb begin
    bus.RdData = '0;
    if (rd_en) begin
      case (offset)
        2'd1:    bus.RdData = {20'd0, 4'(count_q), 4'd0, ovf_q, busy_q, empty, full};
        2'd2:    bus.RdData = 32'(div_q);
        default: bus.RdData = '0;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed scoreboard bench for mmio_uart_tx
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic InputClk;
  logic rst;
  logic tx;
  logic busy;

  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (4),
    .DIV_W      (16),
    .DEFAULT_DIV(16'd16)
  ) dut (
    .InputClk(InputClk),
    .rst     (rst),
    .bus     (bus_if.slave),
    .tx      (tx),
    .busy    (busy)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [7:0]  sb[$];
  logic [31:0] rd;

  initial begin
    InputClk = 1'b0;
    forever #5 InputClk = ~InputClk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic advance(input int n);
    repeat (n) @(negedge InputClk);
  endtask

  // Drive one bus cycle at a negedge; RdData is sampled before the edge.
  task automatic access(input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] ctrl, output logic [31:0] rdata);
    bus_if.AddressBus = addr;
    bus_if.WrData     = data;
    bus_if.ControlBus = ctrl;
    #1 rdata = bus_if.RdData;
    if (ctrl[2]) @(negedge InputClk);
    bus_if.ControlBus = 3'b000;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    access(addr, data, 3'b100, dummy);
  endtask

  task automatic rd_reg(input logic [31:0] addr, output logic [31:0] data);
    access(addr, 32'h0, 3'b010, data);
  endtask

  // Starts pos0 negedges after the first low negedge of a frame; ends at the next frame origin.
  task automatic check_frame(input string tag, input int div, input int pos0);
    logic [7:0] eb;
    logic [9:0] got;
    int pos;
    if (sb.size() == 0) begin
      chk({tag, "_sb_underflow"}, sb.size(), 1);
      eb = 8'h00;
    end else begin
      eb = sb.pop_front();
    end
    pos = pos0;
    for (int k = 0; k < 10; k++) begin
      int target;
      target = k * div + div / 2;
      advance(target - pos);
      pos = target;
      got[k] = tx;
      if (k == 9) chk({tag, "_busy_stop"}, busy, 1'b1);
    end
    chk(tag, got, {1'b1, eb, 1'b0});
    advance(10 * div - pos);
  endtask

  initial begin
    bus_if.AddressBus = '0;
    bus_if.WrData     = '0;
    bus_if.ControlBus = 3'b000;
    rst = 1'b0;

    advance(4);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;
    advance(1);
    rd_reg(BASE + 4, rd);  chk("rst_status", rd, 32'h0000_0002);
    rd_reg(BASE + 8, rd);  chk("rst_baud", rd, 32'd16);

    wr(BASE + 12, 32'h33);
    wr(BASE + 16, 32'h33);
    rd_reg(BASE + 4, rd);  chk("decode_status", rd, 32'h0000_0002);
    rd_reg(BASE + 12, rd); chk("decode_rsvd", rd, 32'h0);
    rd_reg(BASE + 16, rd); chk("decode_outside", rd, 32'h0);
    rd_reg(BASE + 0, rd);  chk("decode_txdata", rd, 32'h0);
    access(BASE + 4, 32'h0, 3'b001, rd); chk("decode_no_rden", rd, 32'h0);
    chk("decode_tx_idle", tx, 1'b1);

    wr(BASE + 8, 32'h0);
    rd_reg(BASE + 8, rd);  chk("baud_zero", rd, 32'd1);
    access(BASE + 8, 32'h4, 3'b110, rd); chk("baud_rw_pre", rd, 32'd1);
    rd_reg(BASE + 8, rd);  chk("baud_rw_post", rd, 32'd4);

    wr(BASE, 32'hA5); sb.push_back(8'hA5);
    chk("single_latency_tx", tx, 1'b1);
    chk("single_latency_busy", busy, 1'b0);
    advance(1);
    chk("single_start_tx", tx, 1'b0);
    chk("single_start_busy", busy, 1'b1);
    check_frame("single_frame", 4, 0);
    chk("single_end_tx", tx, 1'b1);
    chk("single_end_busy", busy, 1'b0);

    wr(BASE + 8, 32'h2);
    wr(BASE, 32'h55); sb.push_back(8'h55);
    wr(BASE, 32'h0F); sb.push_back(8'h0F);
    rd_reg(BASE + 4, rd);  chk("b2b_status_a", rd, 32'h0000_0104);
    check_frame("b2b_frame0", 2, 0);
    rd_reg(BASE + 4, rd);  chk("b2b_status_b", rd, 32'h0000_0006);
    check_frame("b2b_frame1", 2, 0);
    rd_reg(BASE + 4, rd);  chk("b2b_status_c", rd, 32'h0000_0002);
    chk("b2b_end_busy", busy, 1'b0);

    wr(BASE + 8, 32'd16);
    wr(BASE, 32'h11); sb.push_back(8'h11);
    wr(BASE, 32'h22); sb.push_back(8'h22);
    wr(BASE, 32'h33); sb.push_back(8'h33);
    wr(BASE, 32'h44); sb.push_back(8'h44);
    wr(BASE, 32'h66); sb.push_back(8'h66);
    wr(BASE, 32'h77);
    rd_reg(BASE + 4, rd);  chk("ovf_status", rd, 32'h0000_040D);
    wr(BASE + 4, 32'h8);
    rd_reg(BASE + 4, rd);  chk("ovf_cleared", rd, 32'h0000_0405);
    check_frame("ovf_frame0", 16, 5);
    check_frame("ovf_frame1", 16, 0);
    check_frame("ovf_frame2", 16, 0);
    check_frame("ovf_frame3", 16, 0);
    check_frame("ovf_frame4", 16, 0);
    chk("ovf_end_busy", busy, 1'b0);
    chk("ovf_sb_drained", sb.size(), 0);

    wr(BASE + 8, 32'h4);
    wr(BASE, 32'hC3); sb.push_back(8'hC3);
    wr(BASE, 32'h3C); sb.push_back(8'h3C);
    advance(18);
    chk("midrst_bit3_tx", tx, 1'b0);
    chk("midrst_bit3_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_async_tx", tx, 1'b1);
    chk("midrst_async_busy", busy, 1'b0);
    sb.delete();
    advance(2);
    rst = 1'b1;
    advance(1);
    rd_reg(BASE + 4, rd);  chk("midrst_status", rd, 32'h0000_0002);
    rd_reg(BASE + 8, rd);  chk("midrst_baud", rd, 32'd16);
    advance(3);
    chk("midrst_idle_tx", tx, 1'b1);
    chk("midrst_idle_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
